// File: rtl/drive_dsp_gen2.sv
// drive_dsp_gen2 - data signal processor for 157x/1541-style drives.
//
// This block sits between the disk-bit layer and the VIA/CPU side.
// In read mode it deserialises the bitstream, detects sync marks and raises
// a byte-ready handshake that reports overruns. In write mode it serialises
// bytes MSB-first. With format detection built in, it also spots a long run
// of fill bytes, so that sector 0 can be aligned to the buffer start.
//
// Build option:
//   DRIVE_DSP_FMT_DETECT_EN  When defined, the format-run counter and the
//                            fmt_init pulse are built. When undefined,
//                            fmt_init is tied to 0.
//
// Ports:
//   clk, reset   system clock; synchronous active-high reset
//   enable       motor/select enable; 0 holds the block idle
//   bit_clk      one-clk strobe per bit cell
//   rd_bit       read bit, sampled on bit_clk
//   wr_bit       write bit (combinational)
//   mode         1 = read, 0 = write
//   din          next byte to write, loaded on byte completion
//   dout         last deserialised byte
//   soe, ted     byte-ready output enable / acknowledge
//   sync_n       active-low sync indication (combinational)
//   byte_n       active-low byte ready
//   overrun      sticky: a byte completed while byte_n was still low
//   fmt_init     one-clk pulse at the end of a format run
module drive_dsp_gen2 #(
  parameter int                BYTE_W    = 8,
  parameter int                SYNC_BITS = 10,
  parameter logic [BYTE_W-1:0] FMT_BYTE  = 8'h55,
  parameter int                FMT_RUN   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              bit_clk,
  input  logic              rd_bit,
  output logic              wr_bit,
  input  logic              mode,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  input  logic              soe,
  input  logic              ted,
  output logic              sync_n,
  output logic              byte_n,
  output logic              overrun,
  output logic              fmt_init
);

  localparam int CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  logic [CW-1:0]        bit_cnt;
  logic [SYNC_BITS-2:0] shreg;
  logic [SYNC_BITS-1:0] shcur;
  logic [BYTE_W-1:0]    wr_buf;
  logic [CW-1:0]        wr_idx;
  logic                 bc;
  logic                 bc_d;   // bc one clk late; byte_n adds the second stage

  // The incoming bit is part of the sync window in the same cycle.
  assign shcur  = {shreg, rd_bit};
  assign sync_n = ~enable | ~mode | ~&shcur;
  assign bc     = bit_clk & (bit_cnt == CW'(BYTE_W - 1));
  assign wr_idx = CW'(BYTE_W - 1) - bit_cnt;
  assign wr_bit = enable & ~mode & wr_buf[wr_idx];

  always_ff @(posedge clk) begin
    if (reset | ~enable) begin
      bit_cnt <= '0;
      shreg   <= '0;
      wr_buf  <= '0;
      dout    <= '0;
      bc_d    <= 1'b0;
      byte_n  <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (bit_clk) begin
        shreg <= shcur[SYNC_BITS-2:0];
        // A sync mark realigns the byte boundary. A sync on the last bit
        // still completes that byte, because bc was already decoded.
        if (~sync_n | bc) bit_cnt <= '0;
        else              bit_cnt <= bit_cnt + 1'b1;
      end
      if (bc) begin
        dout   <= shcur[BYTE_W-1:0];
        wr_buf <= din;
      end
      bc_d <= bc;
      // A new byte beats a same-cycle acknowledge.
      if (bc_d & soe)       byte_n <= 1'b0;
      else if (ted | ~soe)  byte_n <= 1'b1;
      if (bc & ~byte_n)     overrun <= 1'b1;
      else if (ted)         overrun <= 1'b0;
    end
  end

`ifdef DRIVE_DSP_FMT_DETECT_EN
  localparam int FW = $clog2(FMT_RUN + 1);
  logic [FW-1:0] fmt_cnt;

  // wr_buf at bc is the byte that has just finished going out.
  always_ff @(posedge clk) begin
    if (reset | ~enable | mode) begin
      fmt_cnt  <= '0;
      fmt_init <= 1'b0;
    end else begin
      fmt_init <= 1'b0;
      if (bc) begin
        if (wr_buf == FMT_BYTE) begin
          if (fmt_cnt != FW'(FMT_RUN)) fmt_cnt <= fmt_cnt + 1'b1;
        end else begin
          fmt_init <= (fmt_cnt == FW'(FMT_RUN));
          fmt_cnt  <= '0;
        end
      end
    end
  end
`else
  assign fmt_init = 1'b0;
`endif

endmodule

// File: tb/tb_drive_dsp_gen2.sv
// Testbench for drive_dsp_gen2.
//
// The bench runs directed scenarios with literal expectations, then a
// randomized phase. A behavioural model tracks the following state:
//   - the position within the byte
//   - the run length of consecutive ones
//   - the bit history
//   - the byte being written
//   - the fill-byte run length
// A negedge process compares every DUT output against this model on each cycle.
module tb_drive_dsp_gen2;
  localparam int         BW = 8;
  localparam int         SB = 10;
  localparam int         FR = 1023;
  localparam logic [7:0] FB = 8'h55;

  logic clk = 1'b0;
  logic reset, enable, bit_clk, rd_bit, mode, soe, ted;
  logic [7:0] din, dout;
  logic wr_bit, sync_n, byte_n, overrun, fmt_init;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  int fmt_pulses = 0;

  always #5 clk = ~clk;

  drive_dsp_gen2 dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_clk(bit_clk),
    .rd_bit(rd_bit), .wr_bit(wr_bit), .mode(mode), .din(din), .dout(dout),
    .soe(soe), .ted(ted), .sync_n(sync_n), .byte_n(byte_n),
    .overrun(overrun), .fmt_init(fmt_init)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_pos = 0;
  int         m_run1 = 0;
  int         m_frun = 0;
  logic [31:0] m_hist = '0;
  logic [7:0] m_cur = '0;
  logic [7:0] m_dout = '0;
  logic       m_bn = 1'b1;
  logic       m_ovr = 1'b0;
  logic       m_fmt = 1'b0;
  logic       m_pend = 1'b0;

  always @(posedge clk) begin : model
    logic sy, bcm, bn_n, ov_n, fp;
    if (reset || !enable) begin
      m_pos = 0; m_run1 = 0; m_hist = '0; m_cur = '0; m_dout = '0;
      m_bn = 1'b1; m_ovr = 1'b0; m_fmt = 1'b0; m_frun = 0; m_pend = 1'b0;
    end else begin
      sy  = mode && rd_bit && (m_run1 >= SB - 1);
      bcm = bit_clk && (m_pos == BW - 1);
      fp  = 1'b0;
      if (bcm && !mode) begin
        if (m_cur == FB) m_frun++;
        else begin
`ifdef DRIVE_DSP_FMT_DETECT_EN
          fp = (m_frun >= FR);
`endif
          m_frun = 0;
        end
      end
      if (mode) m_frun = 0;
      ov_n = (bcm && !m_bn) ? 1'b1 : (ted ? 1'b0 : m_ovr);
      bn_n = (m_pend && soe) ? 1'b0 : ((ted || !soe) ? 1'b1 : m_bn);
      if (bcm) begin
        m_dout = 8'((m_hist << 1) | 32'(rd_bit));
        m_cur  = din;
      end
      if (bit_clk) begin
        m_hist = (m_hist << 1) | 32'(rd_bit);
        m_run1 = rd_bit ? ((m_run1 < 100) ? m_run1 + 1 : m_run1) : 0;
        m_pos  = sy ? 0 : (m_pos + 1) % BW;
      end
      m_pend = bcm; m_bn = bn_n; m_ovr = ov_n; m_fmt = fp;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("dout", 32'(dout), 32'(m_dout));
      chk("byte_n", 32'(byte_n), 32'(m_bn));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("fmt_init", 32'(fmt_init), 32'(m_fmt));
      chk("sync_n", 32'(sync_n), 32'(!(enable && mode && rd_bit && (m_run1 >= SB - 1))));
      chk("wr_bit", 32'(wr_bit), 32'(enable && !mode && m_cur[BW-1-m_pos]));
      if (fmt_init) fmt_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic b, input logic r);
    bit_clk = b; rd_bit = r;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b1, v[i]);
    bit_clk = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic fmt_run(input int n, input int exp_pulses, input string nm);
    do_reset();
    mode = 1'b0;
    fmt_pulses = 0;
    din = FB;
    for (int i = 0; i < n; i++) send_byte(8'h00);
    din = 8'h52; send_byte(8'h00);
    din = 8'h00; send_byte(8'h00);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk(nm, 32'(fmt_pulses), 32'(exp_pulses));
  endtask

  initial begin
    logic [7:0] got;
    reset = 1'b1; enable = 1'b1; bit_clk = 1'b0; rd_bit = 1'b0; mode = 1'b0;
    din = '0; soe = 1'b0; ted = 1'b0;
    step(1'b0, 1'b0);
    chk_on = 1'b1;
    // Reset values
    chk("rst_byte_n", 32'(byte_n), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_fmt_init", 32'(fmt_init), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_wr_bit", 32'(wr_bit), 32'd0);
    enable = 1'b0; #1;
    chk("dis_sync_n", 32'(sync_n), 32'd1);
    step(1'b0, 1'b0);
    enable = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;

    // Read sync: ten ones, then 0x52 MSB first
    mode = 1'b1; soe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_clk = 1'b1; rd_bit = 1'b1; #1;
      if (i == 9) chk("sync_low", 32'(sync_n), 32'd0);
      @(posedge clk); #1;
    end
    soe = 1'b1;
    send_byte(8'h52);
    chk("sync_dout", 32'(dout), 32'h52);
    chk("byte_n_t1", 32'(byte_n), 32'd1);
    step(1'b0, 1'b0);
    chk("byte_n_t2", 32'(byte_n), 32'd0);

    // Handshake: ted clears; soe low at the delayed bc suppresses
    ted = 1'b1; step(1'b0, 1'b0); ted = 1'b0;
    chk("ted_clear", 32'(byte_n), 32'd1);
    send_byte(8'h3C);
    soe = 1'b0; step(1'b0, 1'b0);
    soe = 1'b1; step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk("soe_low_no_set", 32'(byte_n), 32'd1);

    // Overrun: two bytes without an acknowledge
    send_byte(8'h12);
    step(1'b0, 1'b0);
    chk("ovr_first_byte_n", 32'(byte_n), 32'd0);
    send_byte(8'h34);
    chk("ovr_set", 32'(overrun), 32'd1);
    step(1'b0, 1'b0);
    ted = 1'b1; step(1'b0, 1'b0); ted = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);
    chk("ovr_byte_n", 32'(byte_n), 32'd1);

    // Write: 0xA5 serialised MSB first after the loading byte
    do_reset();
    mode = 1'b0; din = 8'hA5;
    send_byte(8'h00);
    for (int i = 7; i >= 0; i--) begin
      got[i] = wr_bit;
      step(1'b1, 1'b0);
    end
    bit_clk = 1'b0;
    chk("wr_seq", 32'(got), 32'hA5);

    // Reset in the middle of a byte
    do_reset();
    mode = 1'b1;
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    reset = 1'b1; step(1'b0, 1'b0);
    chk("mid_rst_byte_n", 32'(byte_n), 32'd1);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    send_byte(8'hC3);
    chk("mid_rst_realign", 32'(dout), 32'hC3);

    // Format detection
`ifdef DRIVE_DSP_FMT_DETECT_EN
    fmt_run(FR, 1, "fmt_full_run");
`else
    fmt_run(FR, 0, "fmt_full_run");
`endif
    fmt_run(FR - 1, 0, "fmt_short_run");

    // Randomized phase
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      enable  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      bit_clk = 1'($urandom_range(0, 1));
      rd_bit  = ($urandom_range(0, 9) < 7);
      din     = 8'($urandom);
      soe     = ($urandom_range(0, 9) != 0);
      ted     = ($urandom_range(0, 4) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; enable = 1'b1; bit_clk = 1'b0;
    step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
